// File: rtl/bram_dump_pkg.sv
// Shared constants and FSM encoding for the BRAM dump engine.
package bram_dump_pkg;

    localparam int DUMP_BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        DUMP_IDLE  = 3'd0,
        DUMP_FETCH = 3'd1,
        DUMP_WAIT  = 3'd2,
        DUMP_SEND  = 3'd3,
        DUMP_DONE  = 3'd4
    } dump_state_e;

endpackage

// File: rtl/bram_dump_serializer.sv
// Loads a 32-bit word and emits it LSB-first as 4 bytes under valid/ready.
// Output is registered; data/valid/last hold while the sink stalls.
module bram_dump_serializer
    import bram_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        last_word_i,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        tx_last_o,
    output logic        last_byte_o,
    output logic        byte_accepted_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic        vld_q, vld_d;

    always_comb begin
        byte_accepted_o = vld_q && tx_ready_i;
        last_byte_o     = (idx_q == 2'd3);
        tx_data_o       = word_q[{idx_q, 3'b000} +: 8];
        tx_valid_o      = vld_q;
        tx_last_o       = vld_q && last_byte_o && last_word_i;
    end

    // Byte index wraps 3 -> 0 on the final accept, ready for the next load.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        vld_d  = vld_q;
        if (load_i) begin
            word_d = word_i;
            idx_d  = 2'd0;
            vld_d  = 1'b1;
        end else if (byte_accepted_o) begin
            idx_d = idx_q + 2'd1;
            if (last_byte_o) begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            vld_q  <= vld_d;
        end
    end

endmodule

// File: rtl/bram_dump.sv
// Walks a word range through a BRAM read port and streams it out as bytes.
// Latency: 5 cycles/word (RD_LATENCY=0) or 6 (RD_LATENCY=1) with tx_ready high.
module bram_dump
    import bram_dump_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 9,
    parameter int RD_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  done
);

    dump_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  load;
    logic                  last_word;
    logic                  last_byte;
    logic                  byte_accepted;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^start_addr[1:0];
    assign last_word        = (remaining_q == CNT_WIDTH'(1));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        load        = 1'b0;
        case (state_q)
            DUMP_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        addr_d      = {start_addr[ADDR_WIDTH-1:2], 2'b00};
                        remaining_d = word_count;
                        state_d     = DUMP_FETCH;
                    end else begin
                        state_d = DUMP_DONE;
                    end
                end
            end
            DUMP_FETCH: begin
                if (RD_LATENCY == 0) begin
                    load    = 1'b1;
                    state_d = DUMP_SEND;
                end else begin
                    state_d = DUMP_WAIT;
                end
            end
            DUMP_WAIT: begin
                load    = 1'b1;
                state_d = DUMP_SEND;
            end
            DUMP_SEND: begin
                // Address wraps naturally at the top of the BRAM.
                if (byte_accepted && last_byte) begin
                    addr_d      = addr_q + ADDR_WIDTH'(DUMP_BYTES_PER_WORD);
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    state_d     = last_word ? DUMP_DONE : DUMP_FETCH;
                end
            end
            DUMP_DONE: state_d = DUMP_IDLE;
            default:   state_d = DUMP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DUMP_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    assign mem_addr = addr_q;
    assign busy     = (state_q == DUMP_FETCH) || (state_q == DUMP_WAIT) || (state_q == DUMP_SEND);
    assign done     = (state_q == DUMP_DONE);

    bram_dump_serializer u_ser (
        .clk             (clk),
        .rst             (rst),
        .load_i          (load),
        .word_i          (mem_data[31:0]),
        .last_word_i     (last_word),
        .tx_ready_i      (tx_ready),
        .tx_data_o       (tx_data),
        .tx_valid_o      (tx_valid),
        .tx_last_o       (tx_last),
        .last_byte_o     (last_byte),
        .byte_accepted_o (byte_accepted)
    );

endmodule

// File: tb/tb_bram_dump.sv
// Scoreboard bench driving a combinational-read and a registered-read instance in parallel.
module tb_bram_dump;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] start_addr;
    logic [8:0] word_count;
    logic       tx_ready;

    logic [9:0]  mem_addr0, mem_addr1;
    logic [31:0] mem_data0, mem_data1;
    logic [7:0]  tx_data0, tx_data1;
    logic        tx_valid0, tx_valid1, tx_last0, tx_last1;
    logic        busy0, busy1, done0, done1;

    logic [31:0] mem [256];
    logic [18:0] q0[$];
    logic [18:0] q1[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt [2];
    int          acc [2];
    logic        hold [2];
    logic [8:0]  hold_val [2];
    int          d0, d1;
    logic        bp_en = 1'b0;
    logic [3:0]  bp_pat = 4'b1001;
    int          bp_k = 0;

    always #5 clk = ~clk;

    bram_dump #(.RD_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .word_count(word_count),
        .mem_addr(mem_addr0), .mem_data(mem_data0), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready), .tx_last(tx_last0), .busy(busy0), .done(done0)
    );

    bram_dump #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .word_count(word_count),
        .mem_addr(mem_addr1), .mem_data(mem_data1), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready), .tx_last(tx_last1), .busy(busy1), .done(done1)
    );

    assign mem_data0 = mem[mem_addr0[9:2]];
    always @(posedge clk) mem_data1 <= mem[mem_addr1[9:2]];

    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            tx_ready = bp_pat[bp_k];
            bp_k     = (bp_k + 1) % 4;
        end else begin
            tx_ready = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mon(input int i, input logic v, input logic [7:0] d, input logic l,
                       input logic [9:0] a, input logic dn);
        logic [18:0] e;
        if (dn) done_cnt[i]++;
        if (hold[i]) begin
            check($sformatf("hold_vld%0d", i), {31'd0, v}, 32'd1);
            check($sformatf("hold_dat%0d", i), {23'd0, l, d}, {23'd0, hold_val[i]});
        end
        if (v && tx_ready) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                check($sformatf("spurious%0d", i), 32'd1, 32'd0);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("byte%0d", i), {13'd0, a, l, d}, {13'd0, e});
            end
            acc[i]++;
        end
        hold[i]     = v && !tx_ready;
        hold_val[i] = {l, d};
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold[0] = 1'b0;
            hold[1] = 1'b0;
        end else begin
            mon(0, tx_valid0, tx_data0, tx_last0, mem_addr0, done0);
            mon(1, tx_valid1, tx_data1, tx_last1, mem_addr1, done1);
        end
    end

    task automatic push_expect(input logic [9:0] a, input int cnt);
        logic [9:0]  wa;
        logic [31:0] w;
        for (int k = 0; k < cnt; k++) begin
            wa = {a[9:2], 2'b00} + 10'(4 * k);
            w  = mem[wa[9:2]];
            for (int b = 0; b < 4; b++) begin
                q0.push_back({wa, (k == cnt - 1) && (b == 3), w[8*b +: 8]});
                q1.push_back({wa, (k == cnt - 1) && (b == 3), w[8*b +: 8]});
            end
        end
    endtask

    task automatic launch(input logic [9:0] a, input int cnt);
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = a;
        word_count = 9'(cnt);
        push_expect(a, cnt);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_dump(input string tag, input int budget);
        int n = 0;
        while ((done_cnt[0] == d0 || done_cnt[1] == d1) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_timeout"}, {31'd0, n < budget}, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_done0"}, done_cnt[0], d0 + 1);
        check({tag, "_done1"}, done_cnt[1], d1 + 1);
        check({tag, "_left0"}, q0.size(), 0);
        check({tag, "_left1"}, q1.size(), 0);
        check({tag, "_busy"}, {30'd0, busy0, busy1}, 32'd0);
    endtask

    initial begin
        int a0;
        for (int k = 0; k < 256; k++) mem[k] = 32'hDEAD_0000 | k;
        rst = 1'b1; start = 1'b0; start_addr = '0; word_count = '0; tx_ready = 1'b1;
        done_cnt = '{0, 0}; acc = '{0, 0}; hold = '{0, 0}; hold_val = '{0, 0};
        repeat (3) @(negedge clk);
        check("rst_addr", {22'd0, mem_addr0}, 32'd0);
        check("rst_data", {24'd0, tx_data0}, 32'd0);
        check("rst_flags0", {28'd0, tx_valid0, tx_last0, busy0, done0}, 32'd0);
        check("rst_flags1", {28'd0, tx_valid1, tx_last1, busy1, done1}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        mem[0] = 32'h1122_3344;
        mem[1] = 32'hAABB_CCDD;
        launch(10'h000, 2);
        finish_dump("basic", 200);

        bp_en = 1'b1;
        launch(10'h000, 2);
        finish_dump("bp", 300);
        bp_en = 1'b0;

        mem[255] = 32'h0102_0304;
        mem[0]   = 32'h0506_0708;
        launch(10'h3FE, 2);
        finish_dump("wrap", 200);

        a0 = acc[0];
        launch(10'h010, 0);
        finish_dump("zero", 3);
        check("zero_bytes", acc[0], a0);

        launch(10'h000, 2);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; start_addr = 10'h100; word_count = 9'd5;
        @(posedge clk); #1;
        start = 1'b0;
        finish_dump("ignore", 200);

        mem[0] = 32'hCAFE_F00D; mem[1] = 32'h1234_5678; mem[2] = 32'h9ABC_DEF0;
        a0 = acc[0];
        launch(10'h000, 3);
        for (int n = 0; n < 100 && acc[0] < a0 + 2; n++) begin
            @(negedge clk); #1;
        end
        check("rst_mid_reach", {31'd0, acc[0] >= a0 + 2}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        q0.delete();
        q1.delete();
        @(negedge clk);
        check("rst_mid_vld", {30'd0, tx_valid0, tx_valid1}, 32'd0);
        check("rst_mid_busy", {30'd0, busy0, busy1}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem[2] = 32'h0BAD_BEEF;
        launch(10'h008, 1);
        finish_dump("post_rst", 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
